// File: rtl/serial_addsub_ctrl.sv
// Bit-serial A+B / A-B over WIDTH bits, LSB first, one bit per clock; done pulses WIDTH+1 cycles after accepted start.
// start is ignored while busy; define SERIAL_ADDSUB_OVF_EN to build the signed-overflow flag (otherwise Overflow is tied 0).
module serial_addsub_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Result,
  output logic             Cout,
  output logic             Overflow
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic             w_accept;
  logic             w_run;
  logic             w_last;
  logic             w_sum;
  logic             w_fa_cout;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [WIDTH-1:0] r_result;
  logic [CW-1:0]    r_count;
  logic             r_carry;
  logic             r_cout;

  // The single shared full adder, fed from the shift-register LSBs.
  assign w_sum     = r_a_sh[0] ^ r_b_sh[0] ^ r_carry;
  assign w_fa_cout = (r_a_sh[0] & r_b_sh[0]) | (r_carry & (r_a_sh[0] ^ r_b_sh[0]));

  assign w_run  = (r_state == S_RUN);
  assign w_last = (r_count == LAST);

  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_next   = S_RUN;
          w_accept = 1'b1;
        end
      end
      S_RUN: begin
        if (w_last) w_next = S_DONE;
      end
      S_DONE: begin
        if (start) begin
          w_next   = S_RUN;
          w_accept = 1'b1;
        end else begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_a_sh   <= '0;
      r_b_sh   <= '0;
      r_result <= '0;
      r_count  <= '0;
      r_carry  <= 1'b0;
      r_cout   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        // Subtraction is A + ~B + 1; the +1 enters as the initial carry.
        r_a_sh   <= A;
        r_b_sh   <= Sub ? ~B : B;
        r_carry  <= Sub;
        r_count  <= '0;
        r_result <= '0;
        r_cout   <= 1'b0;
      end else if (w_run) begin
        r_a_sh   <= {1'b0, r_a_sh[WIDTH-1:1]};
        r_b_sh   <= {1'b0, r_b_sh[WIDTH-1:1]};
        r_result <= {w_sum, r_result[WIDTH-1:1]};
        r_carry  <= w_fa_cout;
        r_count  <= r_count + CW'(1);
        if (w_last) r_cout <= w_fa_cout;
      end
    end
  end

`ifdef SERIAL_ADDSUB_OVF_EN
  logic r_ovf;

  // On the MSB cycle r_carry is the carry into the MSB.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ovf <= 1'b0;
    end else if (w_accept) begin
      r_ovf <= 1'b0;
    end else if (w_run && w_last) begin
      r_ovf <= r_carry ^ w_fa_cout;
    end
  end

  assign Overflow = r_ovf;
`else
  assign Overflow = 1'b0;
`endif

  assign busy   = w_run;
  assign done   = (r_state == S_DONE);
  assign Result = r_result;
  assign Cout   = r_cout;

endmodule

// File: tb/tb_serial_addsub_ctrl.sv
// Directed bench for serial_addsub_ctrl at WIDTH=8; overflow expectations follow SERIAL_ADDSUB_OVF_EN.
module tb_serial_addsub_ctrl;

  logic       clk;
  logic       reset;
  logic       start;
  logic [7:0] A;
  logic [7:0] B;
  logic       Sub;
  logic       busy;
  logic       done;
  logic [7:0] Result;
  logic       Cout;
  logic       Overflow;

  int checks;
  int errors;

`ifdef SERIAL_ADDSUB_OVF_EN
  localparam bit OVF_ON = 1'b1;
`else
  localparam bit OVF_ON = 1'b0;
`endif

  serial_addsub_ctrl #(.WIDTH(8)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .A        (A),
    .B        (B),
    .Sub      (Sub),
    .busy     (busy),
    .done     (done),
    .Result   (Result),
    .Cout     (Cout),
    .Overflow (Overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse start for one accept edge, then wait (bounded) for done.
  // lat counts samples taken 1ns after each edge, starting at 1 right after the accept edge.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic s,
                        output int lat, output int busy_cnt, output bit seen);
    A = a; B = b; Sub = s; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 1; busy_cnt = 0; seen = 1'b0;
    while (!done && lat < 20) begin
      if (busy) busy_cnt++;
      @(posedge clk); #1;
      lat++;
    end
    seen = done;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; A = '0; B = '0; Sub = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({busy, done, Result, Cout, Overflow} !== 12'h000) begin
      errors++;
      $display("FAIL reset_state: got busy=%b done=%b Result=%h Cout=%b Ovf=%b, required all 0",
               busy, done, Result, Cout, Overflow);
    end
    // reset and start together: reset wins
    start = 1'b1; A = 8'h11; B = 8'h22;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_beats_start: busy=%b, required 0", busy);
    end
    start = 1'b0; reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_add_basic();
    int lat, bc; bit seen;
    run_op(8'h3C, 8'h0F, 1'b0, lat, bc, seen);
    checks++;
    if (!seen || lat != 9) begin
      errors++;
      $display("FAIL add_latency: done at sample %0d (seen=%b), required 9", lat, seen);
    end
    checks++;
    if (bc != 8) begin
      errors++;
      $display("FAIL add_busy_cycles: busy for %0d cycles, required 8", bc);
    end
    checks++;
    if (Result !== 8'h4B || Cout !== 1'b0 || Overflow !== 1'b0) begin
      errors++;
      $display("FAIL add_3C_0F: Result=%h Cout=%b Ovf=%b, required 4B 0 0", Result, Cout, Overflow);
    end
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || Result !== 8'h4B) begin
      errors++;
      $display("FAIL hold_in_idle: busy=%b done=%b Result=%h, required 0 0 4B", busy, done, Result);
    end
  endtask

  task automatic test_add_wrap();
    int lat, bc; bit seen;
    A = 8'hFF; B = 8'h01; Sub = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    checks++;
    if (Result !== 8'h00 || Cout !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL clear_on_accept: Result=%h Cout=%b busy=%b, required 00 0 1", Result, Cout, busy);
    end
    lat = 1;
    while (!done && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    seen = done; bc = 0;
    checks++;
    if (!seen || Result !== 8'h00 || Cout !== 1'b1 || Overflow !== 1'b0) begin
      errors++;
      $display("FAIL add_FF_01: seen=%b Result=%h Cout=%b Ovf=%b, required 1 00 1 0",
               seen, Result, Cout, Overflow);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_sub();
    int lat, bc; bit seen;
    run_op(8'h10, 8'h20, 1'b1, lat, bc, seen);
    checks++;
    if (!seen || Result !== 8'hF0 || Cout !== 1'b0 || Overflow !== 1'b0) begin
      errors++;
      $display("FAIL sub_10_20: seen=%b Result=%h Cout=%b Ovf=%b, required 1 F0 0 0",
               seen, Result, Cout, Overflow);
    end
    @(posedge clk); #1;
    run_op(8'h80, 8'h01, 1'b1, lat, bc, seen);
    checks++;
    if (!seen || Result !== 8'h7F || Cout !== 1'b1 || Overflow !== OVF_ON) begin
      errors++;
      $display("FAIL sub_80_01: seen=%b Result=%h Cout=%b Ovf=%b, required 1 7F 1 %b",
               seen, Result, Cout, Overflow, OVF_ON);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int s2;
    A = 8'h55; B = 8'h22; Sub = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    // start stays high and operands churn while running
    for (int s = 1; s <= 8; s++) begin
      A = 8'hFF - 8'(s); B = 8'(s * 17); Sub = s[0];
      @(posedge clk); #1;
    end
    checks++;
    if (done !== 1'b1 || Result !== 8'h77 || Cout !== 1'b0) begin
      errors++;
      $display("FAIL b2b_first: done=%b Result=%h Cout=%b, required 1 77 0", done, Result, Cout);
    end
    A = 8'hC8; B = 8'h64; Sub = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_restart: busy=%b, required 1", busy);
    end
    s2 = 1;
    while (!done && s2 < 20) begin
      @(posedge clk); #1;
      s2++;
    end
    checks++;
    if (done !== 1'b1 || s2 != 9) begin
      errors++;
      $display("FAIL b2b_latency: done=%b at sample %0d, required 1 at 9", done, s2);
    end
    checks++;
    if (Result !== 8'h64 || Cout !== 1'b1 || Overflow !== OVF_ON) begin
      errors++;
      $display("FAIL b2b_second: Result=%h Cout=%b Ovf=%b, required 64 1 %b",
               Result, Cout, Overflow, OVF_ON);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_run();
    int lat, bc; bit seen;
    int done_seen;
    A = 8'h12; B = 8'h34; Sub = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || Result !== 8'h00 || Cout !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_run: busy=%b done=%b Result=%h Cout=%b, required 0 0 00 0",
               busy, done, Result, Cout);
    end
    done_seen = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (done) done_seen++;
    end
    checks++;
    if (done_seen != 0) begin
      errors++;
      $display("FAIL no_done_after_abort: %0d done pulses, required 0", done_seen);
    end
    run_op(8'h7F, 8'h01, 1'b0, lat, bc, seen);
    checks++;
    if (!seen || lat != 9 || Result !== 8'h80 || Cout !== 1'b0 || Overflow !== OVF_ON) begin
      errors++;
      $display("FAIL after_abort_op: seen=%b lat=%0d Result=%h Cout=%b Ovf=%b, required 1 9 80 0 %b",
               seen, lat, Result, Cout, Overflow, OVF_ON);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b1; start = 1'b0; A = '0; B = '0; Sub = 1'b0;
    test_reset();
    test_add_basic();
    test_add_wrap();
    test_sub();
    test_back_to_back();
    test_reset_mid_run();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
